// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the DDR tree deserializer.
package serial_deser_pkg;

   typedef enum logic {
      SKIP = 1'b0,
      FILL = 1'b1
   } deser_state_t;

   localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/ddr_capture.sv
// Dual-edge front end: holds the falling-edge half of each bit pair so the
// rest of the design only ever sees a rising-edge-aligned 2-bit pair.
module ddr_capture (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [1:0] pair
);

   logic fall_q;

   // Sample the serial line on the falling edge; this is the earlier bit of the pair.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_q <= 1'b0;
      end else begin
         fall_q <= serial_in;
      end
   end

   assign pair = {serial_in, fall_q};

endmodule

// File: rtl/serial_tree_deserializer.sv
// DDR serial-to-parallel deserializer with a one-entry valid/ready holding
// register. Optional DROP_CNT saturating drop counter is enabled by defining
// SERIAL_DESER_DROP_CNT_EN.
module serial_tree_deserializer
   import serial_deser_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 256,
   parameter int SKIP_CYCLES  = $clog2(OUTPUT_WIDTH)
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    SERIAL_IN,
   output logic [OUTPUT_WIDTH-1:0] PAR_OUT,
   output logic                    PAR_VALID,
   input  logic                    PAR_READY,
   output logic                    OVERRUN
`ifdef SERIAL_DESER_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]   DROP_CNT
`endif
);

   localparam int PAIRS       = OUTPUT_WIDTH / 2;
   localparam int PAIR_W      = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(PAIRS - 1);
   localparam int SKIP_W      = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
   localparam int SKIP_LAST_I = (SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0;
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_LAST_I);
   localparam deser_state_t RESET_STATE = (SKIP_CYCLES == 0) ? FILL : SKIP;

   logic [1:0]              pair;
   deser_state_t            state;
   logic [SKIP_W-1:0]       skip_cnt;
   logic [PAIR_W-1:0]       pair_cnt;
   // The lowest pair of the full shift register is only ever needed at the
   // completion edge, where it comes straight from the frame vector, so the
   // stored part holds the upper OUTPUT_WIDTH-2 bits.
   logic [OUTPUT_WIDTH-3:0] shift_q;
   logic [OUTPUT_WIDTH-1:0] frame;
   logic                    frame_done;
   logic                    frame_drop;

   ddr_capture u_ddr_capture (
      .clk       (CLK),
      .rst_n     (RESET),
      .serial_in (SERIAL_IN),
      .pair      (pair)
   );

   assign frame      = {pair, shift_q};
   assign frame_done = (state == FILL) && (pair_cnt == PAIR_LAST);
   assign frame_drop = frame_done && PAR_VALID && !PAR_READY;

   // Skip the upstream fill latency, then shift one pair in per rising edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= RESET_STATE;
         skip_cnt <= '0;
         pair_cnt <= '0;
         shift_q  <= '0;
      end else begin
         case (state)
            SKIP: begin
               if (skip_cnt == SKIP_LAST) begin
                  state <= FILL;
               end else begin
                  skip_cnt <= skip_cnt + 1'b1;
               end
            end
            FILL: begin
               shift_q  <= frame[OUTPUT_WIDTH-1:2];
               pair_cnt <= frame_done ? '0 : pair_cnt + 1'b1;
            end
            default: begin
               state <= RESET_STATE;
            end
         endcase
      end
   end

   // Hand a completed frame to the holding register, or drop it if the slot is busy.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         PAR_OUT   <= '0;
         PAR_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (frame_done) begin
            if (!PAR_VALID || PAR_READY) begin
               PAR_OUT   <= frame;
               PAR_VALID <= 1'b1;
            end else begin
               OVERRUN <= 1'b1;
            end
         end else if (PAR_VALID && PAR_READY) begin
            PAR_VALID <= 1'b0;
         end
      end
   end

`ifdef SERIAL_DESER_DROP_CNT_EN
   // Count dropped frames, saturating at the all-ones value.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         DROP_CNT <= '0;
      end else if (frame_drop && (DROP_CNT != '1)) begin
         DROP_CNT <= DROP_CNT + 1'b1;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = frame_drop;
`endif

endmodule

// File: doc/serial_tree_deserializer.md
# serial_tree_deserializer

Receive-side counterpart of the latch-based tree serializer. It captures the double-data-rate serial stream, with one bit per clock phase, and reassembles it into `OUTPUT_WIDTH`-bit parallel frames. Completed frames are presented on a valid/ready interface through a one-entry holding register. The block sits directly downstream of the serializer's `SERIAL_OUT`, in the same clock domain.

## Interface
Parameters:
- `OUTPUT_WIDTH`, default 256 — frame width. Must be even and ≥ 4.
- `SKIP_CYCLES`, default `$clog2(OUTPUT_WIDTH)` — rising edges discarded after reset release. Covers the upstream tree fill latency.

Ports:
- `CLK`, in, 1 — single clock. Both edges are used for capture.
- `RESET`, in, 1 — asynchronous, active-low reset.
- `SERIAL_IN`, in, 1 — DDR serial data from the serializer.
- `PAR_OUT`, out, `OUTPUT_WIDTH` — assembled frame, LSB first in time.
- `PAR_VALID`, out, 1 — holding register contains a frame.
- `PAR_READY`, in, 1 — consumer accepts `PAR_OUT` when both valid and ready are high at a rising edge.
- `OVERRUN`, out, 1 — sticky. Set when a completed frame is dropped; cleared only by reset.
- `DROP_CNT`, out, 8 — present only with `SERIAL_DESER_DROP_CNT_EN` (see Configuration).

## Operation
- **Capture**
  - `fall_q` samples `SERIAL_IN` at each negedge.
  - At each posedge the pair {`SERIAL_IN`, `fall_q`} is formed. `fall_q` is earlier in time and takes the lower index.
- **Shift register**
  - `OUTPUT_WIDTH`-bit shift register plus a pair counter, 0 … `OUTPUT_WIDTH`/2−1.
  - Each pair enters at the top and shifts toward bit 0, so the first-received bit ends at `PAR_OUT[0]`.
- **State machine** (`SKIP`, `FILL`)
  - `SKIP`: a skip counter counts posedges with no shifting. After `SKIP_CYCLES` edges, go to `FILL`. If `SKIP_CYCLES` = 0, reset leaves the block directly in `FILL`.
  - `FILL`: shift every posedge. On the edge where the pair counter equals `OUTPUT_WIDTH`/2−1, the frame is complete: {new pair, upper shift bits} forms the full frame and the pair counter wraps to 0.
  - The block stays in `FILL` until reset. The serial stream cannot be stalled.
- **Frame hand-off**, evaluated at the completion edge:
  - Holding register empty, or being drained that same edge (valid & ready): load the frame and set `PAR_VALID`.
  - Otherwise: drop the frame, keep the held frame unchanged, set `OVERRUN`.
- **Consumer handshake**
  - Handshake with no completion: `PAR_VALID` falls.
  - `PAR_OUT` holds stable while valid and not ready.
  - `PAR_READY` is ignored while `PAR_VALID` is low.
- **Reset**
  - Asserting `RESET` at any time, including mid-frame, clears all state immediately: `PAR_OUT`=0, `PAR_VALID`=0, `OVERRUN`=0, `DROP_CNT`=0, state=`SKIP`, all counters=0, `fall_q`=0.
  - A partial frame is discarded.

## Timing
- First frame: `PAR_VALID` rises after posedge number `SKIP_CYCLES` + `OUTPUT_WIDTH`/2 following reset release.
- Steady state: one frame per `OUTPUT_WIDTH`/2 cycles. `PAR_VALID` rises one clock-to-q after the completion edge.
- Back-to-back frames with `PAR_READY` held high: `PAR_VALID` stays high continuously only if `OUTPUT_WIDTH`/2 = 1. Otherwise it pulses for one cycle per frame.
- Reset deassertion is assumed synchronized externally. The first counted edge is the first posedge after release.

## Configuration
- `SERIAL_DESER_DROP_CNT_EN` defined:
  - `DROP_CNT` port exists.
  - Increments on each dropped frame and saturates at 255.
- Undefined:
  - The port and its counter are absent.
  - `OVERRUN` behaviour is identical in both builds.

## Structure
- Package `serial_deser_pkg`: the state enum (`SKIP`, `FILL`) and the `DROP_CNT_W` = 8 constant.
- Sub-module `ddr_capture`: the negedge `fall_q` flop with async active-low reset. It outputs the posedge-aligned 2-bit pair, keeping the dual-edge logic isolated for timing constraints.

## Test plan
Benches use `OUTPUT_WIDTH`=8, `SKIP_CYCLES`=3.
- **Reset values:** hold `RESET`=0 and toggle `CLK` → all outputs 0, `PAR_VALID`=0.
- **First frame:** release reset, drive bits 1,0,1,1,0,0,1,0 in time order after 3 skipped cycles, `PAR_READY`=1 → `PAR_OUT`=8'h4D, `PAR_VALID` high for one cycle after the 7th posedge.
- **Backpressure hold:** `PAR_READY`=0 during a second frame of 8'hA5 while the first is held → first frame stays on `PAR_OUT`, second dropped, `OVERRUN`=1, `DROP_CNT`=1.
- **Drain at completion:** `PAR_READY` rises exactly on a completion edge → new frame loaded, no overrun, `PAR_VALID` remains high.
- **Reset mid-frame:** assert `RESET` after 2 pairs → outputs cleared at once. After release the next frame needs the full skip + 4 cycles.
- **Saturation:** hold `PAR_READY`=0 for 300 frames (`SERIAL_DESER_DROP_CNT_EN` build) → `DROP_CNT`=255, `OVERRUN`=1.
